// File: rtl/ch446q_serial_tx.sv
// CH446Q serial-address transmitter: buffers key-switch events in a small FIFO
// and shifts each one out on DAT/SK/STB (7 address bits MSB-first, then state + strobe).
module ch446q_serial_tx #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [6:0] ev_addr,
  input  logic       ev_state,
  output logic       DAT,
  output logic       SK,
  output logic       STB,
  output logic       busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PH_W  = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [6:0] addr;
    logic       state;
  } ev_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    ADDR_HI,
    DATA_SETUP,
    STROBE,
    DATA_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  ev_t               cur_q, cur_d;
  ev_t               mem_q [FIFO_DEPTH];
  ev_t               mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dat_q, dat_d;
  logic              sk_q, sk_d;
  logic              stb_q, stb_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic              push;
  logic              pop;
  logic              ph_last;
  ev_t               head;

  assign push    = ev_valid & ready_q;
  assign ph_last = (ph_q == PH_LAST);
  assign head    = mem_q[rd_ptr_q];

  // FIFO bookkeeping; ready is derived from the next count so it is never stale.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: ev_addr, state: ev_state};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    ready_d = (count_d != CNT_FULL);
  end

  // Protocol sequencer: next state, phase counter, bit index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cur_d   = head;
          idx_d   = IDX_W'(6);
          state_d = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (ph_last) state_d = ADDR_HI;
      end
      ADDR_HI: begin
        if (ph_last) begin
          if (idx_q != '0) begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ADDR_LO;
          end else begin
            state_d = DATA_SETUP;
          end
        end
      end
      DATA_SETUP: begin
        if (ph_last) state_d = STROBE;
      end
      STROBE: begin
        if (ph_last) state_d = DATA_HOLD;
      end
      DATA_HOLD: begin
        if (ph_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_d != state_q) || (state_q == IDLE)) begin
      ph_d = '0;
    end else begin
      ph_d = ph_q + PH_W'(1);
    end
  end

  // Line levels decoded from the next state so the pins are plain flops.
  always_comb begin
    dat_d  = 1'b0;
    sk_d   = 1'b0;
    stb_d  = 1'b0;
    busy_d = (state_d != IDLE) || (count_d != '0);
    unique case (state_d)
      ADDR_LO: dat_d = cur_d.addr[idx_d];
      ADDR_HI: begin
        dat_d = cur_d.addr[idx_d];
        sk_d  = 1'b1;
      end
      DATA_SETUP, DATA_HOLD: dat_d = cur_d.state;
      STROBE: begin
        dat_d = cur_d.state;
        stb_d = 1'b1;
      end
      default: dat_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      idx_q    <= '0;
      cur_q    <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dat_q    <= 1'b0;
      sk_q     <= 1'b0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      idx_q    <= idx_d;
      cur_q    <= cur_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dat_q    <= dat_d;
      sk_q     <= sk_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign DAT      = dat_q;
  assign SK       = sk_q;
  assign STB      = stb_q;
  assign busy     = busy_q;
  assign ev_ready = ready_q;

endmodule

// File: tb/tb_ch446q_serial_tx.sv
// Directed bench for ch446q_serial_tx with a behavioural CH446Q receiver model
// decoding DAT/SK/STB into a 128-switch array and an event log.
module tb_ch446q_serial_tx;

  localparam int unsigned H     = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_in = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic [6:0] ev_addr = '0;
  logic       ev_state = 1'b0;
  logic       DAT, SK, STB, busy;

  always #5 clk = ~clk;

  ch446q_serial_tx #(.HALF_PERIOD(H), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_addr  (ev_addr),
    .ev_state (ev_state),
    .DAT      (DAT),
    .SK       (SK),
    .STB      (STB),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receiver model: shift on SK rise, latch switch on STB rise.
  logic [6:0] rx_sr = '0;
  logic       rx_sw [128];
  logic [7:0] rx_log [$];
  logic       sk_dat [$];
  time        sk_t [$];
  time        stb_t [$];
  int         stb_cyc = 0;
  int         stb_dat1 = 0;
  int         overlap = 0;

  always @(posedge SK) begin
    rx_sr = {rx_sr[5:0], DAT};
    sk_dat.push_back(DAT);
    sk_t.push_back($time);
  end

  always @(posedge STB) begin
    rx_sw[rx_sr] = DAT;
    rx_log.push_back({rx_sr, DAT});
    stb_t.push_back($time);
  end

  always @(negedge clk) begin
    if (STB) begin
      stb_cyc++;
      if (DAT) stb_dat1++;
    end
    if (STB && SK) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [6:0] a, input logic s, output time t_acc);
    int n;
    n = 0;
    ev_addr  = a;
    ev_state = s;
    ev_valid = 1'b1;
    while (!ev_ready && n < 500) begin
      tick();
      n++;
    end
    check_eq("ready_wait", 32'(n < 500), 32'd1);
    @(posedge clk);
    t_acc = $time;
    #1;
    ev_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    check_eq("idle_wait", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    time        t0, ta, tb2, t1, e_edge;
    int         sb, lb, nb, n, acc, sk0;
    logic       rdy, reas_seen;
    logic [6:0] a24;
    logic [6:0] ev_tab [8];

    for (int i = 0; i < 128; i++) rx_sw[i] = 1'b0;

    // Power-on reset
    repeat (3) tick();
    check_eq("rst_dat",   32'(DAT),      32'd0);
    check_eq("rst_sk",    32'(SK),       32'd0);
    check_eq("rst_stb",   32'(STB),      32'd0);
    check_eq("rst_busy",  32'(busy),     32'd0);
    check_eq("rst_ready", 32'(ev_ready), 32'd1);
    rst_in = 1'b1;
    repeat (2) tick();

    // Single event 0x24 on
    sb = sk_dat.size();
    lb = rx_log.size();
    stb_cyc = 0;
    stb_dat1 = 0;
    push_ev(7'h24, 1'b1, t0);
    nb = 0;
    while (busy && nb < 300) begin
      nb++;
      tick();
    end
    check_eq("busy_cycles", 32'(nb), 32'd69);
    check_eq("sk_rises", 32'(sk_dat.size() - sb), 32'd7);
    a24 = 7'h24;
    if (sk_dat.size() >= sb + 7) begin
      for (int k = 0; k < 7; k++)
        check_eq($sformatf("addr_bit%0d", 6 - k), 32'(sk_dat[sb + k]), 32'(a24[6 - k]));
      check_eq("first_sk_latency", 32'((sk_t[sb] - t0) / 10), 32'(1 + H));
    end
    check_eq("stb_cycles", 32'(stb_cyc), 32'(H));
    check_eq("stb_dat_high", 32'(stb_dat1), 32'(H));
    check_eq("rx_sw_24", 32'(rx_sw[7'h24]), 32'd1);
    check_eq("log_cnt_single", 32'(rx_log.size() - lb), 32'd1);

    // Special key RESET (X=8, Y=6) on then off, back to back
    lb = rx_log.size();
    push_ev(7'h68, 1'b1, ta);
    push_ev(7'h68, 1'b0, tb2);
    check_eq("back2back_accept", 32'((tb2 - ta) / 10), 32'd1);
    wait_idle();
    check_eq("log_cnt_reset_key", 32'(rx_log.size() - lb), 32'd2);
    if (rx_log.size() >= lb + 2) begin
      check_eq("reset_key_on",  32'(rx_log[lb]),     32'h0D1);
      check_eq("reset_key_off", 32'(rx_log[lb + 1]), 32'h0D0);
      check_eq("event_spacing", 32'((stb_t[stb_t.size() - 1] - stb_t[stb_t.size() - 2]) / 10), 32'd69);
    end
    check_eq("rx_reset_line", 32'(rx_sw[7'h68]), 32'd0);

    // FIFO fill with ev_valid held high, 8 distinct events
    for (int i = 0; i < 8; i++) ev_tab[i] = 7'((i + 1) * 8'h11);
    lb = rx_log.size();
    acc = 0;
    n = 0;
    reas_seen = 1'b0;
    t1 = 0;
    ev_addr = ev_tab[0];
    ev_state = 1'b0;
    ev_valid = 1'b1;
    rdy = ev_ready;
    while (acc < 8 && n < 2000) begin
      @(posedge clk);
      n++;
      if (rdy) begin
        acc++;
        if (acc == 1) t1 = $time;
      end
      e_edge = $time;
      #1;
      if (rdy) begin
        if (acc == 4) check_eq("ready_after_acc4", 32'(ev_ready), 32'd1);
        if (acc == 5) check_eq("ready_drop_acc5", 32'(ev_ready), 32'd0);
      end else if (ev_ready && !reas_seen) begin
        reas_seen = 1'b1;
        check_eq("ready_reassert", 32'((e_edge - t1) / 10), 32'd70);
      end
      if (acc < 8) begin
        ev_addr  = ev_tab[acc];
        ev_state = acc[0];
      end else begin
        ev_valid = 1'b0;
      end
      rdy = ev_ready;
    end
    ev_valid = 1'b0;
    check_eq("fill_accepts", 32'(acc), 32'd8);
    wait_idle();
    check_eq("log_cnt_fill", 32'(rx_log.size() - lb), 32'd8);
    if (rx_log.size() >= lb + 8)
      for (int k = 0; k < 8; k++)
        check_eq($sformatf("fill_order%0d", k), 32'(rx_log[lb + k]), 32'({ev_tab[k], k[0]}));

    // Reset during ADDR_HI of bit 3 with two events queued
    sb = sk_dat.size();
    push_ev(7'h7F, 1'b1, ta);
    push_ev(7'h2A, 1'b0, ta);
    push_ev(7'h15, 1'b1, ta);
    n = 0;
    while (sk_dat.size() < sb + 4 && n < 500) begin
      tick();
      n++;
    end
    check_eq("reach_bit3", 32'(sk_dat.size() - sb), 32'd4);
    lb = rx_log.size();
    ev_addr  = 7'h33;
    ev_state = 1'b1;
    ev_valid = 1'b1;
    rst_in   = 1'b0;
    #1;
    check_eq("async_rst_dat",   32'(DAT),      32'd0);
    check_eq("async_rst_sk",    32'(SK),       32'd0);
    check_eq("async_rst_stb",   32'(STB),      32'd0);
    check_eq("async_rst_busy",  32'(busy),     32'd0);
    check_eq("async_rst_ready", 32'(ev_ready), 32'd1);
    ev_valid = 1'b0;
    tick();
    rst_in = 1'b1;
    sk0 = sk_dat.size();
    repeat (20) tick();
    check_eq("quiet_sk", 32'(sk_dat.size() - sk0), 32'd0);
    check_eq("quiet_busy", 32'(busy), 32'd0);
    check_eq("queue_dropped", 32'(rx_log.size() - lb), 32'd0);
    push_ev(7'h05, 1'b1, ta);
    wait_idle();
    check_eq("log_cnt_after_rst", 32'(rx_log.size() - lb), 32'd1);
    if (rx_log.size() >= lb + 1)
      check_eq("decode_after_rst", 32'(rx_log[lb]), 32'h00B);
    check_eq("rx_sw_05", 32'(rx_sw[7'h05]), 32'd1);

    // Simultaneous push and pop at count 1
    lb = rx_log.size();
    ev_addr = 7'h31; ev_state = 1'b1; ev_valid = 1'b1;
    tick();
    ev_addr = 7'h4C; ev_state = 1'b0;
    tick();
    check_eq("pp1_count", 32'(dut.count_q), 32'd1);
    check_eq("pp1_ready", 32'(ev_ready), 32'd1);
    ev_valid = 1'b0;
    repeat (68) tick();
    check_eq("pp2_pre_dat", 32'(DAT), 32'd0);
    ev_addr = 7'h2B; ev_state = 1'b1; ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    check_eq("pp2_count", 32'(dut.count_q), 32'd1);
    check_eq("pp2_ready", 32'(ev_ready), 32'd1);
    check_eq("pp2_pop_dat", 32'(DAT), 32'd1);
    wait_idle();
    check_eq("log_cnt_pp", 32'(rx_log.size() - lb), 32'd3);
    if (rx_log.size() >= lb + 3) begin
      check_eq("pp_ev0", 32'(rx_log[lb]),     32'h063);
      check_eq("pp_ev1", 32'(rx_log[lb + 1]), 32'h098);
      check_eq("pp_ev2", 32'(rx_log[lb + 2]), 32'h057);
    end

    check_eq("sk_stb_overlap", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
